traffic_sensor: RTL and testbench



---
 rtl/traffic_sensor.sv | 93 +++++++++
 tb/tb_traffic_sensor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/traffic_sensor.sv
// Two-street vehicle queue model: counts waiting cars per street and releases
// one car every DEP_CYC green cycles, producing the traffic-sensor flags.
module traffic_sensor_chan #(
  parameter int QW      = 4,
  parameter int DEP_CYC = 4
) (
  input  logic          c_clk,
  input  logic          c_rstn,
  input  logic          c_arr,
  input  logic [1:0]    c_L,
  output logic [QW-1:0] c_q,
  output logic          c_ovf
);
  localparam int TW = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEP_CYC - 1);
  localparam logic [QW-1:0] QMAX   = {QW{1'b1}};

  logic [TW-1:0] t_p0;
  logic          green;
  logic          wrap;
  logic          dep;

  assign green = (c_L == 2'b00);
  assign wrap  = green && (t_p0 == T_LAST);
  assign dep   = wrap && (c_q != '0);

  // Departure timer: free-runs while green so a late arrival leaves on the next wrap
  always_ff @(posedge c_clk or negedge c_rstn) begin
    if (!c_rstn) begin
      t_p0 <= '0;
    end else if (!green || wrap) begin
      t_p0 <= '0;
    end else begin
      t_p0 <= t_p0 + 1'b1;
    end
  end

  // Queue state; a simultaneous arrival and departure cancel, even at full
  always_ff @(posedge c_clk or negedge c_rstn) begin
    if (!c_rstn) begin
      c_q   <= '0;
      c_ovf <= 1'b0;
    end else if (c_arr && !dep) begin
      if (c_q != QMAX) begin
        c_q <= c_q + 1'b1;
      end else begin
        c_ovf <= 1'b1;
      end
    end else if (dep && !c_arr) begin
      c_q <= c_q - 1'b1;
    end
  end
endmodule

module traffic_sensor #(
  parameter int QW      = 4,
  parameter int DEP_CYC = 4
) (
  input  logic          c_clk,
  input  logic          c_rstn,
  input  logic          c_arrA,
  input  logic          c_arrB,
  input  logic [1:0]    c_LA,
  input  logic [1:0]    c_LB,
  output logic          c_TA,
  output logic          c_TB,
  output logic [QW-1:0] c_qA,
  output logic [QW-1:0] c_qB,
  output logic          c_ovfA,
  output logic          c_ovfB
);
  traffic_sensor_chan #(.QW(QW), .DEP_CYC(DEP_CYC)) u_chan_a (
    .c_clk  (c_clk),
    .c_rstn (c_rstn),
    .c_arr  (c_arrA),
    .c_L    (c_LA),
    .c_q    (c_qA),
    .c_ovf  (c_ovfA)
  );

  traffic_sensor_chan #(.QW(QW), .DEP_CYC(DEP_CYC)) u_chan_b (
    .c_clk  (c_clk),
    .c_rstn (c_rstn),
    .c_arr  (c_arrB),
    .c_L    (c_LB),
    .c_q    (c_qB),
    .c_ovf  (c_ovfB)
  );

  // Occupancy is a pure decode of the registered counts
  assign c_TA = (c_qA != '0);
  assign c_TB = (c_qB != '0);
endmodule

// File: tb/tb_traffic_sensor.sv
// Directed bench for traffic_sensor with QW=4, DEP_CYC=4.
module tb_traffic_sensor;
  logic       c_clk = 1'b0;
  logic       c_rstn;
  logic       c_arrA, c_arrB;
  logic [1:0] c_LA, c_LB;
  logic       c_TA, c_TB;
  logic [3:0] c_qA, c_qB;
  logic       c_ovfA, c_ovfB;

  int tests = 0;
  int fails = 0;

  traffic_sensor #(.QW(4), .DEP_CYC(4)) dut (
    .c_clk  (c_clk),
    .c_rstn (c_rstn),
    .c_arrA (c_arrA),
    .c_arrB (c_arrB),
    .c_LA   (c_LA),
    .c_LB   (c_LB),
    .c_TA   (c_TA),
    .c_TB   (c_TB),
    .c_qA   (c_qA),
    .c_qB   (c_qB),
    .c_ovfA (c_ovfA),
    .c_ovfB (c_ovfB)
  );

  always #5 c_clk = ~c_clk;

  task automatic step(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    c_rstn = 1'b0;
    c_arrA = 1'b0;
    c_arrB = 1'b0;
    c_LA   = 2'b10;
    c_LB   = 2'b10;
    step(2);
    chk("rst_qA", c_qA, 0);
    chk("rst_TA", c_TA, 0);
    chk("rst_qB", c_qB, 0);
    chk("rst_ovfB", c_ovfB, 0);
    c_rstn = 1'b1;

    // arrivals on red
    c_arrA = 1'b1;
    step(1);
    chk("arr_lat_qA", c_qA, 1);
    chk("arr_lat_TA", c_TA, 1);
    step(2);
    c_arrA = 1'b0;
    chk("red_qA3", c_qA, 3);
    step(20);
    chk("red_hold_qA", c_qA, 3);
    chk("red_hold_TA", c_TA, 1);

    // drain on green: departures at k+3, k+7, k+11
    c_LA = 2'b00;
    step(3);
    chk("drain_pre", c_qA, 3);
    step(1);
    chk("drain_k3", c_qA, 2);
    step(3);
    chk("drain_pre2", c_qA, 2);
    step(1);
    chk("drain_k7", c_qA, 1);
    step(4);
    chk("drain_k11", c_qA, 0);
    chk("drain_TA", c_TA, 0);
    step(4);
    chk("drain_empty", c_qA, 0);

    // yellow stall restarts the timer
    c_LA   = 2'b10;
    c_arrA = 1'b1;
    step(2);
    c_arrA = 1'b0;
    chk("stall_fill", c_qA, 2);
    c_LA = 2'b00;
    step(2);
    c_LA = 2'b01;
    step(10);
    chk("yellow_nodep", c_qA, 2);
    c_LA = 2'b00;
    step(3);
    chk("regreen_pre", c_qA, 2);
    step(1);
    chk("regreen_dep", c_qA, 1);

    // green -> yellow on the would-be wrap edge: no departure
    step(3);
    c_LA = 2'b01;
    step(1);
    chk("yellow_at_wrap", c_qA, 1);
    c_LA = 2'b11;
    step(8);
    chk("lb11_as_red", c_qA, 1);

    // asynchronous reset mid-queue
    c_LA   = 2'b10;
    c_arrA = 1'b1;
    step(4);
    c_arrA = 1'b0;
    chk("pre_rst_qA5", c_qA, 5);
    #2;
    c_rstn = 1'b0;
    #1;
    chk("async_rst_qA", c_qA, 0);
    chk("async_rst_TA", c_TA, 0);
    chk("async_rst_ovfA", c_ovfA, 0);
    step(1);
    c_rstn = 1'b1;
    step(1);
    chk("post_rst_qA", c_qA, 0);

    // saturation on street B
    c_arrB = 1'b1;
    step(15);
    chk("satB_full", c_qB, 15);
    chk("satB_noovf", c_ovfB, 0);
    step(1);
    chk("satB_hold", c_qB, 15);
    chk("satB_ovf", c_ovfB, 1);
    chk("satB_TB", c_TB, 1);
    chk("indep_qA", c_qA, 0);
    c_arrB = 1'b0;
    c_LB   = 2'b00;
    step(3);
    chk("satB_pre_dep", c_qB, 15);
    c_arrB = 1'b1;
    step(1);
    c_arrB = 1'b0;
    chk("satB_arr_dep", c_qB, 15);
    chk("satB_ovf_keep", c_ovfB, 1);
    step(4);
    chk("satB_dep", c_qB, 14);
    chk("satB_ovf_sticky", c_ovfB, 1);
    chk("satB_ovfA_clear", c_ovfA, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
